fpga_tx_arbiter: RTL and testbench
==================================

Name: fpga_tx_arbiter

Overview:
Round-robin scheduler that shares the single FPGA-to-FPGA byte transmitter FSM among N local requesters, such as keypad, UART bridge and status reporter.
- Captures the winning requester's byte and kicks the transmitter with a one-cycle sent pulse.
- Tracks the transmitter's busy/finish handshake and reports per-requester completion.
- A watchdog recovers from a link partner that never acknowledges, by resetting the transmitter.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width passed to transmitter load path
TIMEOUT_CYC, 4095, max cycles from kick to transmitter idle before abort
TXRST_CYC, 2, cycles tx_reset is held on abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  N_REQ  per-requester request level; held until grant
req_data  in  N_REQ*DATA_W  packed bytes; requester i at bits [i*DATA_W +: DATA_W]
grant  out  N_REQ  one-hot, one-cycle pulse: byte of requester i captured
done  out  N_REQ  one-hot, one-cycle pulse: requester i byte fully sent and transmitter idle
timeout_err  out  N_REQ  one-hot, one-cycle pulse: requester i byte aborted by watchdog
tx_data  out  DATA_W  byte to transmitter; stable from LATCH until next grant
tx_sent  out  1  one-cycle start pulse to transmitter
tx_reset  out  1  active-high reset to transmitter, driven only on abort
tx_busy  in  1  transmitter busy (high in every non-idle state)
tx_finish  in  1  transmitter finish (high while awaiting final acknowledge)
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, rr_ptr=N_REQ-1, tx_data=0, watchdog=0.
  - All outputs 0.
  - Reset mid-transfer abandons silently: no done, no err.
- States: IDLE, LATCH, KICK, WAIT_BUSY, WAIT_FIN, WAIT_IDLE, ABORT.
- IDLE:
  - Accepted only if tx_busy==0; otherwise remain.
  - If any req bit is set, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register the winner index and go to LATCH.
- LATCH (1 cycle):
  - tx_data <= req_data[winner].
  - grant[winner]=1.
  - rr_ptr <= winner.
  - -> KICK.
- KICK (1 cycle): tx_sent=1, watchdog cleared, -> WAIT_BUSY.
- WAIT_BUSY: wait tx_busy==1, then -> WAIT_FIN. If tx_finish is already high on entry, go directly to WAIT_IDLE.
- WAIT_FIN: wait tx_finish==1, then -> WAIT_IDLE.
- WAIT_IDLE: wait tx_busy==0. On that cycle done[winner]=1 and -> IDLE.
- Latency:
  - From IDLE sampling req to grant pulse: 1 cycle.
  - grant to tx_sent: 1 cycle.
  - Minimum IDLE-to-IDLE cost is 4 cycles plus the transmitter time.
- Watchdog:
  - Counts every cycle in WAIT_BUSY, WAIT_FIN and WAIT_IDLE.
  - When count reaches TIMEOUT_CYC: timeout_err[winner]=1 and -> ABORT.
  - Counter width is clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- ABORT:
  - tx_reset=1 for TXRST_CYC cycles, then -> IDLE.
  - The aborted requester loses its turn; rr_ptr stays at the winner.
- Simultaneous events:
  - tx_finish and tx_busy falling in the same cycle inside WAIT_FIN: treat as WAIT_IDLE satisfied and pulse done.
  - Timeout coinciding with completion: completion wins, no err.
- Requests that deassert before grant are dropped with no pulse.
- A req bit held through its own done is re-arbitrated normally; it waits behind any other pending requesters.
- Only one grant, done or err bit is high in any cycle.
- Wrap-around: rr_ptr+1 wraps from N_REQ-1 to 0.

Decomposition:
- Package fpga_link_pkg holds:
  - the state encoding constants (IDLE..ABORT)
  - DATA_W default
  - the transmitter handshake timing constants shared with the transmitter and receiver FSMs.
- Sub-module rr_picker: combinational round-robin priority encoder. Inputs req and rr_ptr; outputs valid and index. Reusable by the future receiver-side dispatcher.

Test Plan:
1. Single request: req=4'b0010 with byte 0xA5, transmitter model acks after 3 cycles per bit. Required: grant[1] 1 cycle after req, tx_sent the next cycle, tx_data=0xA5, done[1] exactly when tx_busy falls.
2. All four requesting continuously from reset (bytes 0x10,0x21,0x32,0x43). Required: grant order 0,1,2,3,0, and tx_data sequence 0x10,0x21,0x32,0x43,0x10.
3. Fairness wrap: rr_ptr=2, req=4'b1011. Required: grant[3] first, then grant[0], then grant[1].
4. Dead link: transmitter never acks, TIMEOUT_CYC=50. Required: timeout_err[winner] exactly 50 cycles after entering WAIT_BUSY, tx_reset high 2 cycles, no done, then IDLE; next requester is granted normally.
5. Reset mid-transfer: reset=0 during WAIT_FIN. Required: all outputs 0 on the next cycle, no done or err, rr_ptr=N_REQ-1; a fresh req=4'b0001 is granted to index 0.
6. Transmitter busy at start: tx_busy=1 while req=4'b0100. Required: no grant until tx_busy=0, then grant[2] 1 cycle later.

Source files
------------

// File: rtl/fpga_link_pkg.sv
// Shared constants for the FPGA-to-FPGA byte link: arbiter state encoding,
// default byte width and transmitter handshake timing.
package fpga_link_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LATCH     = 3'd1;
    localparam logic [2:0] ST_KICK      = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_FIN  = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
    localparam logic [2:0] ST_ABORT     = 3'd6;

    localparam int DATA_W_DEF = 8;

    // Longest kick-to-idle time tolerated from the link partner, and how long
    // the transmitter is held in reset after giving up on it.
    localparam int TX_TIMEOUT_CYC = 4095;
    localparam int TX_RESET_CYC   = 2;

endpackage

// File: rtl/fpga_tx_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request bit after
// rr_ptr, scanning upwards with wrap-around.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        valid = 1'b0;
        index = '0;
        // Scan from the farthest candidate to the nearest so the nearest set
        // bit after rr_ptr is the last one written and therefore wins.
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/fpga_tx_arbiter.sv
// Round-robin scheduler sharing one byte transmitter among N_REQ requesters,
// with a kick-to-idle watchdog that resets a transmitter stuck on a dead link.
module fpga_tx_arbiter
    import fpga_link_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TX_TIMEOUT_CYC,
    parameter int TXRST_CYC   = TX_RESET_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          timeout_err,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_sent,
    output logic                      tx_reset,
    input  logic                      tx_busy,
    input  logic                      tx_finish,
    output logic                      arb_busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int RC_W  = $clog2(TXRST_CYC + 1);

    logic [2:0]        state_q,   state_d;
    logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]  winner_q,  winner_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [WD_W-1:0]   wdog_q,    wdog_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  winner_oh;
    logic              wdog_hit;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    assign winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << winner_q;
    assign wdog_hit  = (wdog_q == WD_W'(TIMEOUT_CYC));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        tx_data_d   = tx_data_q;
        wdog_d      = wdog_q;
        rst_cnt_d   = rst_cnt_q;
        grant       = '0;
        done        = '0;
        timeout_err = '0;
        tx_sent     = 1'b0;
        tx_reset    = 1'b0;

        // The watchdog saturates at the limit; the wait states leave on a hit.
        if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_FIN ||
             state_q == ST_WAIT_IDLE) && !wdog_hit) begin
            wdog_d = wdog_q + WD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!tx_busy && pick_valid) begin
                    winner_d = pick_idx;
                    state_d  = ST_LATCH;
                end
            end
            ST_LATCH: begin
                grant     = winner_oh;
                tx_data_d = req_data[int'(winner_q)*DATA_W +: DATA_W];
                rr_ptr_d  = winner_q;
                state_d   = ST_KICK;
            end
            ST_KICK: begin
                tx_sent = 1'b1;
                wdog_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (wdog_hit) begin
                    timeout_err = winner_oh;
                    rst_cnt_d   = '0;
                    state_d     = ST_ABORT;
                end else if (tx_busy) begin
                    state_d = tx_finish ? ST_WAIT_IDLE : ST_WAIT_FIN;
                end
            end
            // Completion is checked ahead of the watchdog so a transfer that
            // ends on the limit cycle reports done rather than an error.
            ST_WAIT_FIN: begin
                if (!tx_busy) begin
                    done    = winner_oh;
                    state_d = ST_IDLE;
                end else if (tx_finish) begin
                    state_d = ST_WAIT_IDLE;
                end else if (wdog_hit) begin
                    timeout_err = winner_oh;
                    rst_cnt_d   = '0;
                    state_d     = ST_ABORT;
                end
            end
            ST_WAIT_IDLE: begin
                if (!tx_busy) begin
                    done    = winner_oh;
                    state_d = ST_IDLE;
                end else if (wdog_hit) begin
                    timeout_err = winner_oh;
                    rst_cnt_d   = '0;
                    state_d     = ST_ABORT;
                end
            end
            ST_ABORT: begin
                tx_reset = 1'b1;
                if (rst_cnt_q == RC_W'(TXRST_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= IDX_W'(N_REQ - 1);
            winner_q  <= '0;
            tx_data_q <= '0;
            wdog_q    <= '0;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            winner_q  <= winner_d;
            tx_data_q <= tx_data_d;
            wdog_q    <= wdog_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign arb_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpga_tx_arbiter.sv
// Directed bench for fpga_tx_arbiter: the transmitter handshake is driven
// step by step alongside the requests, and outputs are checked every cycle.
module tb_fpga_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    logic        tx_busy = 1'b0;
    logic        tx_finish = 1'b0;
    logic [3:0]  grant, done, timeout_err;
    logic [7:0]  tx_data;
    logic        tx_sent, tx_reset, arb_busy;

    int total = 0;
    int bad   = 0;

    fpga_tx_arbiter #(
        .N_REQ       (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (50),
        .TXRST_CYC   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .timeout_err (timeout_err),
        .tx_data     (tx_data),
        .tx_sent     (tx_sent),
        .tx_reset    (tx_reset),
        .tx_busy     (tx_busy),
        .tx_finish   (tx_finish),
        .arb_busy    (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then let the
    // combinational outputs settle before anything is sampled.
    task automatic drive(input logic [3:0] r, input logic b, input logic f);
        @(negedge clk);
        req       = r;
        tx_busy   = b;
        tx_finish = f;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".grant"},    32'(grant),       32'h0);
        check({tag, ".done"},     32'(done),        32'h0);
        check({tag, ".err"},      32'(timeout_err), 32'h0);
        check({tag, ".tx_data"},  32'(tx_data),     32'h0);
        check({tag, ".tx_sent"},  32'(tx_sent),     32'h0);
        check({tag, ".tx_reset"}, 32'(tx_reset),    32'h0);
        check({tag, ".arb_busy"}, 32'(arb_busy),    32'h0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b0; req = '0; tx_busy = 1'b0; tx_finish = 1'b0;
        @(negedge clk);
        #1;
        check_quiet(tag);
        reset = 1'b1;
    endtask

    // Transmitter side of one transfer, starting on the first WAIT_BUSY cycle:
    // n_busy busy-only cycles, n_fin busy+finish cycles, then busy falls.
    task automatic tx_ack(input string tag, input logic [3:0] r, input int n_busy,
                          input int n_fin, input logic fin_last, input logic [3:0] exp_done);
        for (int i = 0; i < n_busy; i++) begin
            drive(r, 1'b1, 1'b0);
            check({tag, ".busy_done"}, 32'(done),        32'h0);
            check({tag, ".busy_err"},  32'(timeout_err), 32'h0);
        end
        for (int i = 0; i < n_fin; i++) begin
            drive(r, 1'b1, 1'b1);
            check({tag, ".fin_done"}, 32'(done), 32'h0);
        end
        drive(r, 1'b0, fin_last);
        check({tag, ".done"},      32'(done),        32'(exp_done));
        check({tag, ".done_err"},  32'(timeout_err), 32'h0);
        check({tag, ".done_busy"}, 32'(arb_busy),    32'h1);
    endtask

    // One full arbitration: IDLE sample, LATCH (grant), KICK (tx_sent), transfer.
    task automatic serve(input string tag, input logic [3:0] r, input logic [3:0] exp_g,
                         input logic [7:0] exp_d, input logic [3:0] r_after,
                         input int n_busy, input int n_fin, input logic fin_last);
        drive(r, 1'b0, 1'b0);
        check({tag, ".idle_grant"}, 32'(grant),    32'h0);
        check({tag, ".idle_busy"},  32'(arb_busy), 32'h0);
        check({tag, ".idle_txrst"}, 32'(tx_reset), 32'h0);
        drive(r, 1'b0, 1'b0);
        check({tag, ".grant"},      32'(grant),    32'(exp_g));
        check({tag, ".latch_sent"}, 32'(tx_sent),  32'h0);
        check({tag, ".latch_busy"}, 32'(arb_busy), 32'h1);
        drive(r_after, 1'b0, 1'b0);
        check({tag, ".tx_sent"},    32'(tx_sent),  32'h1);
        check({tag, ".tx_data"},    32'(tx_data),  32'(exp_d));
        check({tag, ".kick_grant"}, 32'(grant),    32'h0);
        tx_ack(tag, r_after, n_busy, n_fin, fin_last, exp_g);
    endtask

    initial begin
        apply_reset("reset");

        // Single request; 8 bits at 3 cycles per bit keeps the transmitter
        // busy for 24 cycles, the last two with finish raised.
        req_data = {8'h43, 8'h32, 8'hA5, 8'h10};
        serve("single", 4'b0010, 4'b0010, 8'hA5, 4'b0000, 22, 2, 1'b0);
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};

        // Transmitter still busy: request 2 waits in IDLE.
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1, 1'b0);
            check("busy_start.grant",    32'(grant),    32'h0);
            check("busy_start.arb_busy", 32'(arb_busy), 32'h0);
        end
        serve("busy_start", 4'b0100, 4'b0100, 8'h32, 4'b0000, 4, 1, 1'b0);

        // rr_ptr=2, req=1011: order 3, 0, 1. Also covers finish already high
        // in WAIT_BUSY, and busy falling with finish inside WAIT_FIN.
        serve("wrap3", 4'b1011, 4'b1000, 8'h43, 4'b0011, 0, 3, 1'b0);
        serve("wrap0", 4'b0011, 4'b0001, 8'h10, 4'b0010, 4, 1, 1'b0);
        serve("wrap1", 4'b0010, 4'b0010, 8'h21, 4'b0000, 5, 0, 1'b1);

        // All four requesting continuously from reset.
        apply_reset("reset2");
        serve("all_a", 4'b1111, 4'b0001, 8'h10, 4'b1111, 4, 1, 1'b0);
        serve("all_b", 4'b1111, 4'b0010, 8'h21, 4'b1111, 4, 1, 1'b0);
        serve("all_c", 4'b1111, 4'b0100, 8'h32, 4'b1111, 4, 1, 1'b0);
        serve("all_d", 4'b1111, 4'b1000, 8'h43, 4'b1111, 4, 1, 1'b0);
        serve("all_e", 4'b1111, 4'b0001, 8'h10, 4'b1111, 4, 1, 1'b0);

        // Dead link: rr_ptr=0, req=0110 grants 1, transmitter never answers.
        drive(4'b0110, 1'b0, 1'b0);
        drive(4'b0110, 1'b0, 1'b0);
        check("dead.grant", 32'(grant), 32'h2);
        drive(4'b0110, 1'b0, 1'b0);
        check("dead.tx_sent", 32'(tx_sent), 32'h1);
        for (int i = 0; i < 50; i++) begin
            drive(4'b0110, 1'b0, 1'b0);
            check("dead.early_err", 32'(timeout_err), 32'h0);
            check("dead.early_done", 32'(done), 32'h0);
        end
        drive(4'b0110, 1'b0, 1'b0);
        check("dead.err",        32'(timeout_err), 32'h2);
        check("dead.err_done",   32'(done),        32'h0);
        check("dead.err_txrst",  32'(tx_reset),    32'h0);
        drive(4'b0110, 1'b0, 1'b0);
        check("dead.txrst1",     32'(tx_reset),    32'h1);
        check("dead.txrst1_err", 32'(timeout_err), 32'h0);
        check("dead.txrst1_busy",32'(arb_busy),    32'h1);
        drive(4'b0110, 1'b0, 1'b0);
        check("dead.txrst2",     32'(tx_reset),    32'h1);
        check("dead.txrst2_done",32'(done),        32'h0);
        // Requester 1 lost its turn: 2 goes next, then 1.
        serve("after_dead2", 4'b0110, 4'b0100, 8'h32, 4'b0010, 4, 1, 1'b0);
        serve("after_dead1", 4'b0010, 4'b0010, 8'h21, 4'b0000, 4, 1, 1'b0);

        // Completion on the very cycle the watchdog reaches its limit.
        serve("coincide", 4'b0001, 4'b0001, 8'h10, 4'b0000, 49, 1, 1'b0);

        // Reset during WAIT_FIN of a transfer to requester 0 (rr_ptr becomes 0).
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b0);
        check("midrst.grant", 32'(grant), 32'h1);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        check("midrst.in_fin", 32'(arb_busy), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_quiet("midrst");
        reset = 1'b1;
        tx_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b0, 1'b0);
            check("midrst.quiet_done", 32'(done),        32'h0);
            check("midrst.quiet_err",  32'(timeout_err), 32'h0);
            check("midrst.quiet_busy", 32'(arb_busy),    32'h0);
        end
        // rr_ptr back at 3: req=1001 must go to 0 first, then 3.
        serve("post_rst0", 4'b1001, 4'b0001, 8'h10, 4'b1000, 4, 1, 1'b0);
        serve("post_rst3", 4'b1000, 4'b1000, 8'h43, 4'b0000, 4, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
